// File: rtl/multi_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multi_txn_ctrl
// Description : Round-robin multi-channel transaction engine with per-channel
//               error locking and sticky interrupt status.
// Revision    : 1.0  initial release
// ============================================================================
module multi_txn_ctrl #(
  parameter int NCH       = 4,
  parameter int ACK_LAT   = 5,
  parameter int ERR_LIMIT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] stop_in,
  input  logic [NCH-1:0] err_in,
  input  logic [NCH-1:0] irq_clr,
  input  logic [NCH-1:0] unlock,
  output logic           rdy,
  output logic           start,
  output logic [NCH-1:0] gnt,
  output logic [NCH-1:0] ack,
  output logic           endd,
  output logic           stop_o,
  output logic           er,
  output logic [NCH-1:0] lock,
  output logic [NCH-1:0] irq_stat,
  output logic           irq
);

  localparam int C_IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int C_CW = $clog2(ERR_LIMIT + 1);
  localparam int C_LW = $clog2(ACK_LAT);
  localparam logic [NCH-1:0] C_ONE = NCH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [C_IW-1:0]     r_gidx;
  logic [C_LW-1:0]     r_cnt;
  logic [C_CW-1:0]     r_ecnt [NCH];
  logic                r_rdy, r_start, r_endd, r_stop, r_er, r_irq;
  logic [NCH-1:0]      r_gnt, r_ack, r_lock, r_irq_stat;

  logic [NCH-1:0]      w_elig, w_oh, w_gnt_n, w_ack_n, w_lock_set, w_lock_n, w_irq_n;
  logic [C_IW-1:0]     w_cand, w_sel, w_gidx_n;
  logic                w_found, w_err, w_stop, w_launch, w_er_n, w_stop_n, w_done_n;

  always_comb begin
    w_elig = req & ~r_lock;
    w_sel   = '0;
    w_found = 1'b0;
    w_cand  = r_gidx;
    // r_gidx is the last owner, so the scan begins one channel past it
    for (int i = 0; i < NCH; i++) begin
      w_cand = (w_cand == C_IW'(NCH - 1)) ? '0 : w_cand + C_IW'(1);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end

    w_err  = err_in[r_gidx];
    w_stop = stop_in[r_gidx];

    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_n = S_RUN;
      S_RUN: begin
        if (w_err || w_stop)                  w_state_n = S_ABORT;
        else if (r_cnt == C_LW'(ACK_LAT - 1)) w_state_n = S_DONE;
      end
      default: w_state_n = S_IDLE;
    endcase

    w_launch = (r_state == S_IDLE) && w_found;
    w_gidx_n = w_launch ? w_sel : r_gidx;
    w_oh     = C_ONE << w_gidx_n;
    w_er_n   = (r_state == S_RUN) && w_err;
    w_stop_n = (r_state == S_RUN) && !w_err && w_stop;
    w_done_n = (w_state_n == S_DONE);
    w_ack_n  = w_done_n ? w_oh : '0;
    w_gnt_n  = (w_state_n != S_IDLE) ? w_oh : '0;

    for (int ch = 0; ch < NCH; ch++) begin
      w_lock_set[ch] = w_er_n && (r_gidx == C_IW'(ch)) &&
                       (r_ecnt[ch] == C_CW'(ERR_LIMIT - 1));
    end
    w_lock_n = (r_lock & ~unlock) | w_lock_set;
    w_irq_n  = w_ack_n | w_lock_set | (r_irq_stat & ~irq_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gidx     <= C_IW'(NCH - 1);
      r_cnt      <= '0;
      r_rdy      <= 1'b1;
      r_start    <= 1'b0;
      r_endd     <= 1'b0;
      r_stop     <= 1'b0;
      r_er       <= 1'b0;
      r_irq      <= 1'b0;
      r_gnt      <= '0;
      r_ack      <= '0;
      r_lock     <= '0;
      r_irq_stat <= '0;
      for (int ch = 0; ch < NCH; ch++) r_ecnt[ch] <= '0;
    end else begin
      r_gidx     <= w_gidx_n;
      r_cnt      <= w_launch ? '0 : ((r_state == S_RUN) ? r_cnt + C_LW'(1) : r_cnt);
      r_rdy      <= (w_state_n == S_IDLE);
      r_start    <= w_launch;
      r_endd     <= w_done_n;
      r_stop     <= w_stop_n;
      r_er       <= w_er_n;
      r_gnt      <= w_gnt_n;
      r_ack      <= w_ack_n;
      r_lock     <= w_lock_n;
      r_irq_stat <= w_irq_n;
      r_irq      <= |w_irq_n;
      // An outcome on the owning channel takes precedence over a coincident unlock
      for (int ch = 0; ch < NCH; ch++) begin
        if (w_er_n && (r_gidx == C_IW'(ch)))
          r_ecnt[ch] <= r_ecnt[ch] + C_CW'(1);
        else if (w_done_n && (r_gidx == C_IW'(ch)))
          r_ecnt[ch] <= '0;
        else if (unlock[ch])
          r_ecnt[ch] <= '0;
      end
    end
  end

  assign rdy      = r_rdy;
  assign start    = r_start;
  assign gnt      = r_gnt;
  assign ack      = r_ack;
  assign endd     = r_endd;
  assign stop_o   = r_stop;
  assign er       = r_er;
  assign lock     = r_lock;
  assign irq_stat = r_irq_stat;
  assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_multi_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_txn_ctrl
// Description : Directed self-checking bench for multi_txn_ctrl (defaults).
// Revision    : 1.0  initial release
// ============================================================================
module tb_multi_txn_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, stop_in, err_in, irq_clr, unlock;
  logic       rdy, start, endd, stop_o, er, irq;
  logic [3:0] gnt, ack, lock, irq_stat;

  int n_chk = 0;
  int n_err = 0;

  multi_txn_ctrl #(.NCH(4), .ACK_LAT(5), .ERR_LIMIT(3)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .stop_in  (stop_in),
    .err_in   (err_in),
    .irq_clr  (irq_clr),
    .unlock   (unlock),
    .rdy      (rdy),
    .start    (start),
    .gnt      (gnt),
    .ack      (ack),
    .endd     (endd),
    .stop_o   (stop_o),
    .er       (er),
    .lock     (lock),
    .irq_stat (irq_stat),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    @(negedge clk);
    while (start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, start, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0; stop_in = '0; err_in = '0; irq_clr = '0; unlock = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = '0; stop_in = '0; err_in = '0; irq_clr = '0; unlock = '0;
    repeat (2) @(negedge clk);
    check("rst_rdy", rdy, 1);
    check("rst_gnt", gnt, 0);
    check("rst_start", start, 0);
    check("rst_lock", lock, 0);
    check("rst_irqstat", irq_stat, 0);
    check("rst_irq", irq, 0);
    rst = 1'b0;

    // single request on channel 0
    req = 4'b0001;
    wait_start("s1");
    check("s1_gnt_t0", gnt, 4'b0001);
    check("s1_rdy_t0", rdy, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("s1_gnt_run", gnt, 4'b0001);
      check("s1_ack_early", ack, 0);
      check("s1_endd_early", endd, 0);
      check("s1_start_once", start, 0);
    end
    @(negedge clk);
    check("s1_ack", ack, 4'b0001);
    check("s1_endd", endd, 1);
    check("s1_gnt_t5", gnt, 4'b0001);
    req = '0;
    @(negedge clk);
    check("s1_rdy_t6", rdy, 1);
    check("s1_gnt_t6", gnt, 0);
    check("s1_ack_t6", ack, 0);
    check("s1_irqstat", irq_stat, 4'b0001);
    check("s1_irq", irq, 1);
    irq_clr = 4'b0001;
    @(negedge clk);
    irq_clr = '0;
    check("s1_irqclr", irq_stat, 0);
    check("s1_irq_off", irq, 0);

    // round robin with all channels requesting
    do_reset();
    req = 4'b1111;
    wait_start("rr");
    for (int g = 0; g < 5; g++) begin
      if (g > 0) begin
        @(negedge clk);
        check("rr_start", start, 1);
      end
      check("rr_gnt", gnt, 32'(1) << (g % 4));
      repeat (5) @(negedge clk);
      check("rr_ack", ack, 32'(1) << (g % 4));
      check("rr_endd", endd, 1);
      if (g == 4) req = '0;
      @(negedge clk);
      check("rr_rdy_gap", rdy, 1);
      check("rr_gnt_gap", gnt, 0);
    end

    // three consecutive errors lock channel 2
    do_reset();
    req    = 4'b0100;
    err_in = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      wait_start("lk");
      check("lk_gnt", gnt, 4'b0100);
      @(negedge clk);
      check("lk_er", er, 1);
      check("lk_stop", stop_o, 0);
      check("lk_ack", ack, 0);
      check("lk_lock", lock, (k == 3) ? 4'b0100 : 4'b0000);
      check("lk_irqstat", irq_stat, (k == 3) ? 4'b0100 : 4'b0000);
      @(negedge clk);
      check("lk_rdy", rdy, 1);
    end
    repeat (3) begin
      @(negedge clk);
      check("lk_skip_start", start, 0);
      check("lk_skip_rdy", rdy, 1);
    end

    // locked channel 2 skipped; irq_clr coinciding with ack loses to the set
    req = 4'b0110;
    wait_start("ic");
    check("ic_gnt", gnt, 4'b0010);
    repeat (4) @(negedge clk);
    irq_clr = 4'b0010;
    @(negedge clk);
    irq_clr = '0;
    req = '0;
    check("ic_ack", ack, 4'b0010);
    check("ic_irqstat_set", irq_stat, 4'b0110);
    @(negedge clk);
    check("ic_irqstat_hold", irq_stat, 4'b0110);
    irq_clr = 4'b0110;
    @(negedge clk);
    irq_clr = '0;
    check("ic_irqstat_clr", irq_stat, 0);
    check("ic_irq_off", irq, 0);
    err_in = '0;
    unlock = 4'b0100;
    @(negedge clk);
    unlock = '0;
    check("ul_lock", lock, 0);

    // err and stop together in the last RUN cycle
    req = 4'b0001;
    wait_start("es");
    repeat (4) @(negedge clk);
    stop_in = 4'b0001;
    err_in  = 4'b0001;
    @(negedge clk);
    stop_in = '0;
    err_in  = '0;
    req     = '0;
    check("es_er", er, 1);
    check("es_stop", stop_o, 0);
    check("es_ack", ack, 0);
    check("es_endd", endd, 0);
    check("es_gnt", gnt, 4'b0001);
    @(negedge clk);
    check("es_rdy", rdy, 1);

    // stop alone
    req = 4'b0001;
    wait_start("st");
    stop_in = 4'b0001;
    @(negedge clk);
    stop_in = '0;
    req     = '0;
    check("st_stop", stop_o, 1);
    check("st_er", er, 0);
    check("st_ack", ack, 0);

    // reset in the third RUN cycle aborts silently
    @(negedge clk);
    req = 4'b0001;
    wait_start("rs");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    check("rs_rdy", rdy, 1);
    check("rs_gnt", gnt, 0);
    check("rs_ack", ack, 0);
    check("rs_er", er, 0);
    check("rs_stop", stop_o, 0);
    @(negedge clk);
    check("rs_ack_after", ack, 0);
    check("rs_endd_after", endd, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_txn_ctrl.md
MULTI_TXN_CTRL -- requirements
Module: multi_txn_ctrl

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning the number of requesting channels (legal range 2..16).
REQ-002 The block SHALL have parameter ACK_LAT, default 5, meaning the cycles from start to ack on a successful transaction (legal range 2..255).
REQ-003 The block SHALL have parameter ERR_LIMIT, default 3, meaning the number of consecutive errors after which a channel is locked (legal range 1..15).
REQ-004 clk  in  1  the only clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  NCH  per-channel request level; the requester holds it until ack or abort.
REQ-007 stop_in  in  NCH  per-channel abort request; only the granted channel's bit is used.
REQ-008 err_in  in  NCH  per-channel error indication; only the granted channel's bit is used.
REQ-009 irq_clr  in  NCH  per-channel interrupt-status clear pulse.
REQ-010 unlock  in  NCH  per-channel pulse that clears lock and the error count.
REQ-011 rdy  out  1  engine idle, ready to arbitrate.
REQ-012 start  out  1  one-cycle pulse on the first RUN cycle.
REQ-013 gnt  out  NCH  one-hot owner, held from the start cycle through the terminating cycle.
REQ-014 ack  out  NCH  one-cycle pulse to the owner on successful completion.
REQ-015 endd, stop_o, er  out  1 each  one-cycle termination pulses: success, stop-abort, error-abort.
REQ-016 lock  out  NCH  channel locked; its req is ignored.
REQ-017 irq_stat  out  NCH  sticky per-channel interrupt status.
REQ-018 irq  out  1  OR of irq_stat.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DONE and ABORT; all outputs SHALL be registered.
REQ-020 In IDLE, rdy SHALL be 1 and gnt SHALL be 0; in every other state, rdy SHALL be 0.
REQ-021 In IDLE, if any bit of (req & ~lock) is set, the engine SHALL select one channel round-robin and enter RUN on the next cycle; otherwise it SHALL stay in IDLE.
REQ-022 Round-robin SHALL search starting at the channel after the last granted one; after reset, channel 0 SHALL have highest priority.
REQ-023 On entry to RUN, start SHALL be 1 for exactly one cycle, gnt SHALL be set one-hot, and the cycle counter SHALL be cleared to 0.
REQ-024 With no abort, RUN SHALL last exactly ACK_LAT cycles; the next cycle SHALL be DONE, so ack[g] and endd are asserted exactly ACK_LAT cycles after start.
REQ-025 In RUN, if err_in[g] or stop_in[g] is sampled high, the next cycle SHALL be ABORT, er (err) or stop_o (stop only) SHALL pulse, and ack SHALL NOT be asserted.
REQ-026 err_in SHALL take priority over stop_in when both are sampled in the same cycle.
REQ-027 An abort sampled in the last RUN cycle SHALL take priority over completion.
REQ-028 DONE and ABORT SHALL last one cycle each and always return to IDLE, so rdy is 1 for at least one cycle between transactions.
REQ-029 start, endd, stop_o and er SHALL be mutually exclusive in every cycle.
REQ-030 changes to req during RUN/DONE/ABORT SHALL have no effect.
REQ-031 Each channel SHALL have a consecutive-error counter of width clog2(ERR_LIMIT+1).
REQ-032 The error counter SHALL increment on er for that channel, clear on endd for that channel, and be unchanged by stop_o.
REQ-033 When a channel's error counter reaches ERR_LIMIT, lock[ch] SHALL set in the same cycle as the er pulse.
REQ-034 Once a channel is locked, er for it SHALL never pulse more than ERR_LIMIT times in a row.
REQ-035 unlock[ch] SHALL clear lock[ch] and the channel's error counter on the next cycle; unlock SHALL have no effect on a transaction already in flight.
REQ-036 irq_stat[ch] SHALL set on an ack to ch and on the setting of lock[ch], and SHALL clear on irq_clr[ch].
REQ-037 If a set and irq_clr coincide in the same cycle, the set SHALL win.

Reset
REQ-038 While rst is high, at the next edge the block SHALL enter IDLE with rdy=1 and start, endd, stop_o, er, gnt, ack, lock, irq_stat, irq and all error counters at 0.
REQ-039 While rst is high, the round-robin pointer SHALL be set to favour channel 0.
REQ-040 Reset SHALL have effect mid-transaction: the block aborts silently, with no ack, er or stop_o pulse.

Verification
REQ-041 The bench SHALL drive req=0001 with defaults -> start at cycle t, gnt=0001 for cycles t..t+5, ack[0] and endd at t+5, rdy=1 at t+6.
REQ-042 The bench SHALL drive req=1111 held continuously -> grants in the order 0,1,2,3,0, with one rdy cycle between grants.
REQ-043 The bench SHALL drive err_in[2] in RUN for 3 consecutive grants of channel 2 -> er pulses 3 times, lock[2]=1 and irq_stat[2]=1 on the third, and channel 2 is then skipped by arbitration.
REQ-044 The bench SHALL drive stop_in and err_in together on the owner in the 5th RUN cycle -> er=1, stop_o=0, no ack.
REQ-045 The bench SHALL assert irq_clr[1] in the same cycle as ack[1] -> irq_stat[1] stays 1; a later irq_clr[1] alone -> irq_stat[1]=0 and irq=0.
REQ-046 The bench SHALL assert rst in the 3rd RUN cycle -> next cycle rdy=1, gnt=0, with no ack, er or stop_o pulse.
